// File: rtl/spram_asym_wide_write.sv
// Simple-dual-port RAM whose write port is RATIO lanes of RD_WIDTH wide, read port one lane.
// Define SPRAM_ASYM_OUTREG_EN to add a second output register (read latency 2).
module spram_asym_wide_write #(
  parameter  int RD_WIDTH = 8,
  parameter  int RATIO    = 2,
  parameter  int WR_DEPTH = 1024,
  localparam int RD_DEPTH = WR_DEPTH * RATIO,
  localparam int RA_W     = $clog2(RD_DEPTH),
  localparam int WA_W     = $clog2(WR_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rce,
  input  logic [RA_W-1:0]           ra,
  output logic [RD_WIDTH-1:0]       rq,
  output logic                      rq_valid,
  input  logic                      wce,
  input  logic [WA_W-1:0]           wa,
  input  logic [RD_WIDTH*RATIO-1:0] wd,
  input  logic [RATIO-1:0]          wbe
);

  generate
    if (!(RATIO == 1 || RATIO == 2 || RATIO == 4 || RATIO == 8)) begin : g_bad_ratio
      $error("spram_asym_wide_write: RATIO must be 1, 2, 4 or 8");
    end
  endgenerate

  logic [RD_WIDTH-1:0] mem [RD_DEPTH];

  // Lane i of write word wa lands at read address wa*RATIO+i, i.e. {wa, i}.
  always_ff @(posedge clk) begin
    if (wce && rst_n) begin
      for (int i = 0; i < RATIO; i++) begin
        if (wbe[i]) mem[RA_W'(int'(wa) * RATIO + i)] <= wd[i*RD_WIDTH +: RD_WIDTH];
      end
    end
  end

  logic [RD_WIDTH-1:0] rd1_d, rd1_q;
  logic                vld1_d, vld1_q;

  // Non-blocking memory update makes a same-edge read return the old word.
  always_comb begin
    rd1_d  = rd1_q;
    vld1_d = rce;
    if (rce) rd1_d = mem[ra];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_q  <= '0;
      vld1_q <= 1'b0;
    end else begin
      rd1_q  <= rd1_d;
      vld1_q <= vld1_d;
    end
  end

`ifdef SPRAM_ASYM_OUTREG_EN
  logic [RD_WIDTH-1:0] rd2_d, rd2_q;
  logic                vld2_d, vld2_q;

  // Second stage advances only when stage 1 holds a valid read.
  always_comb begin
    rd2_d  = rd2_q;
    vld2_d = vld1_q;
    if (vld1_q) rd2_d = rd1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd2_q  <= '0;
      vld2_q <= 1'b0;
    end else begin
      rd2_q  <= rd2_d;
      vld2_q <= vld2_d;
    end
  end

  assign rq       = rd2_q;
  assign rq_valid = vld2_q;
`else
  assign rq       = rd1_q;
  assign rq_valid = vld1_q;
`endif

endmodule

// File: tb/tb_spram_asym_wide_write.sv
// Directed bench: RATIO=2 vector table plus RATIO=4 lane-mapping and reset sequences.
module tb_spram_asym_wide_write;

`ifdef SPRAM_ASYM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // RATIO=2 instance
  logic        rce2, wce2;
  logic [10:0] ra2;
  logic [9:0]  wa2;
  logic [15:0] wd2;
  logic [1:0]  wbe2;
  logic [7:0]  rq2;
  logic        rqv2;

  // RATIO=4 instance
  logic        rce4, wce4;
  logic [11:0] ra4;
  logic [9:0]  wa4;
  logic [31:0] wd4;
  logic [3:0]  wbe4;
  logic [7:0]  rq4;
  logic        rqv4;

  spram_asym_wide_write #(.RD_WIDTH(8), .RATIO(2), .WR_DEPTH(1024)) u2 (
    .clk(clk), .rst_n(rst_n), .rce(rce2), .ra(ra2), .rq(rq2), .rq_valid(rqv2),
    .wce(wce2), .wa(wa2), .wd(wd2), .wbe(wbe2));

  spram_asym_wide_write #(.RD_WIDTH(8), .RATIO(4), .WR_DEPTH(1024)) u4 (
    .clk(clk), .rst_n(rst_n), .rce(rce4), .ra(ra4), .rq(rq4), .rq_valid(rqv4),
    .wce(wce4), .wa(wa4), .wd(wd4), .wbe(wbe4));

  typedef struct {
    logic        rce;
    logic [10:0] ra;
    logic        wce;
    logic [9:0]  wa;
    logic [15:0] wd;
    logic [1:0]  wbe;
    logic [7:0]  exp_rq;
    logic        exp_vld;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle2();
    rce2 = 1'b0; ra2 = '0; wce2 = 1'b0; wa2 = '0; wd2 = '0; wbe2 = '0;
  endtask

  task automatic idle4();
    rce4 = 1'b0; ra4 = '0; wce4 = 1'b0; wa4 = '0; wd4 = '0; wbe4 = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w4;
    int k;

    //          rce ra   wce wa  wd        wbe    exp_rq vld
    vecs[0]  = '{0, 0,   1,  3,  16'h1234, 2'b11, 8'h00, 0};
    vecs[1]  = '{0, 0,   1,  3,  16'hFFFF, 2'b10, 8'h00, 0};
    vecs[2]  = '{1, 6,   0,  0,  16'h0000, 2'b00, 8'h34, 1};
    vecs[3]  = '{1, 7,   0,  0,  16'h0000, 2'b00, 8'hFF, 1};
    vecs[4]  = '{0, 0,   1,  0,  16'h0055, 2'b01, 8'hFF, 0};
    vecs[5]  = '{1, 0,   1,  0,  16'h00AA, 2'b01, 8'h55, 1};
    vecs[6]  = '{1, 0,   0,  0,  16'h0000, 2'b00, 8'hAA, 1};
    vecs[7]  = '{0, 0,   0,  0,  16'h0000, 2'b00, 8'hAA, 0};
    vecs[8]  = '{0, 0,   0,  0,  16'h0000, 2'b00, 8'hAA, 0};
    vecs[9]  = '{0, 0,   0,  0,  16'h0000, 2'b00, 8'hAA, 0};
    vecs[10] = '{0, 0,   1,  3,  16'h0000, 2'b00, 8'hAA, 0};
    vecs[11] = '{0, 0,   0,  3,  16'h0000, 2'b11, 8'hAA, 0};
    vecs[12] = '{1, 6,   0,  0,  16'h0000, 2'b00, 8'h34, 1};
    vecs[13] = '{1, 7,   0,  0,  16'h0000, 2'b00, 8'hFF, 1};

    rst_n = 1'b0;
    idle2();
    idle4();
    repeat (2) @(posedge clk);
    #1;
    chk("reset rq2", 32'(rq2), 32'h0);
    chk("reset rqv2", 32'(rqv2), 32'h0);
    chk("reset rq4", 32'(rq4), 32'h0);
    chk("reset rqv4", 32'(rqv4), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: vector j's result is observed LAT-1 edges after its own edge.
    for (int j = 0; j < NV + LAT - 1; j++) begin
      if (j < NV) begin
        rce2 = vecs[j].rce; ra2 = vecs[j].ra; wce2 = vecs[j].wce;
        wa2 = vecs[j].wa; wd2 = vecs[j].wd; wbe2 = vecs[j].wbe;
      end else begin
        idle2();
      end
      @(posedge clk);
      #1;
      k = j - LAT + 1;
      if (k >= 0) begin
        chk($sformatf("vec%0d rq", k), 32'(rq2), 32'(vecs[k].exp_rq));
        chk($sformatf("vec%0d rq_valid", k), 32'(rqv2), 32'(vecs[k].exp_vld));
      end
    end
    idle2();

    // Lane mapping on RATIO=4: lane 0 is the lowest read address.
    w4 = 32'hDDCCBBAA;
    wce4 = 1'b1; wa4 = 10'd5; wd4 = w4; wbe4 = 4'hF;
    @(posedge clk);
    #1;
    idle4();
    for (int c = 0; c < 4 + LAT - 1; c++) begin
      if (c < 4) begin
        rce4 = 1'b1;
        ra4  = 12'(20 + c);
      end else begin
        idle4();
      end
      @(posedge clk);
      #1;
      k = c - LAT + 1;
      if (k >= 0) begin
        chk($sformatf("lane%0d rq", k), 32'(rq4), 32'(w4[k*8 +: 8]));
        chk($sformatf("lane%0d rq_valid", k), 32'(rqv4), 32'h1);
      end else begin
        chk("lane pipeline fill rq_valid", 32'(rqv4), 32'h0);
      end
    end
    idle4();
    @(posedge clk);
    #1;
    chk("lane after idle rq_valid", 32'(rqv4), 32'h0);
    chk("lane after idle rq hold", 32'(rq4), 32'hDD);

    // Mid-run async reset with rce high clears outputs without an edge.
    rce2 = 1'b1; ra2 = 11'd6;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset rq", 32'(rq2), 32'h0);
    chk("async reset rq_valid", 32'(rqv2), 32'h0);
    // Writes during reset must be suppressed.
    rce2 = 1'b0; wce2 = 1'b1; wa2 = 10'd0; wd2 = 16'hFFFF; wbe2 = 2'b11;
    @(posedge clk);
    #1;
    idle2();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post-reset idle%0d rq_valid", c), 32'(rqv2), 32'h0);
    end
    rce2 = 1'b1; ra2 = 11'd0;
    @(posedge clk);
    #1;
    idle2();
    repeat (LAT - 1) @(posedge clk);
    #1;
    chk("write suppressed in reset", 32'(rq2), 32'hAA);

    // Read issued, reset asserted before the next edge: its pulse is dropped.
    @(posedge clk);
    #1;
    rce4 = 1'b1; ra4 = 12'd21;
    @(posedge clk);
    #1;
    idle4();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("dropped read%0d rq_valid", c), 32'(rqv4), 32'h0);
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spram_asym_wide_write.md
# spram_asym_wide_write

Parametrised simple-dual-port block RAM with a write port `RATIO` times wider than the read port. It generalises the fixed 16/8, 32/16 and 32/8 asymmetric memories into one block with per-lane write enables, a read-valid flag and an optional second output register. It is mapped onto qlf_k6n10f BRAM by the memory-inference flow and used as a width converter in front of narrow consumers.

## Interface
- `RD_WIDTH`, 8: read data width in bits; one memory word.
- `RATIO`, 2: write width divided by read width; must be 1, 2, 4 or 8. Any other value stops elaboration with `$error`.
- `WR_DEPTH`, 1024: number of write-side words. Read depth is `WR_DEPTH*RATIO`.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rce` input 1: read enable.
- `ra` input `$clog2(WR_DEPTH*RATIO)`: read address, in read-word units.
- `rq` output `RD_WIDTH`: registered read data.
- `rq_valid` output 1: `rq` carries data from a read issued by `rce`.
- `wce` input 1: write enable.
- `wa` input `$clog2(WR_DEPTH)`: write address, in write-word units.
- `wd` input `RD_WIDTH*RATIO`: write data.
- `wbe` input `RATIO`: per-lane write enable; bit i gates lane i.

## Operation
- Storage: `WR_DEPTH*RATIO` words of `RD_WIDTH` bits. Contents are not reset; they are undefined until written.
- Write:
  - On a clock edge with `wce=1` and `rst_n=1`, each lane i with `wbe[i]=1` writes `wd[i*RD_WIDTH +: RD_WIDTH]` to address `{wa, i[$clog2(RATIO)-1:0]}`.
  - Lane 0 is the lowest read address. For `RATIO=1`, the address is `wa` alone and `wbe[0]` gates the write.
  - Lanes with `wbe[i]=0` are left unchanged. `wce=0` ignores `wbe`.
- Read:
  - On an edge with `rce=1`, the read stage captures `memory[ra]`.
  - With `rce=0`, `rq` holds its last value. It is never cleared by idle cycles.
- `rq_valid` is the registered `rce`, aligned to the stage that drives `rq`.
- Read-during-write to the same address on the same edge is read-first: `rq` returns the old contents. The new data is visible to a read on the next edge.
- Reset:
  - Reset is asynchronous. `rq` = 0, `rq_valid` = 0, and any output-pipeline register = 0.
  - While `rst_n=0`, memory writes are suppressed.
  - A read in flight when reset asserts is dropped; no `rq_valid` pulse follows it.
  - Release is synchronous-safe: the first edge with `rst_n=1` may accept `rce`/`wce`.

## Timing
- Base read latency is 1: `rce` and `ra` are sampled at edge N; `rq` and `rq_valid=1` are valid after edge N.
- Write latency is 1: data written at edge N is readable by a read sampled at edge N+1, giving `rq` after N+1.
- Back-to-back reads run at one per cycle with no bubbles.
- Reads and writes are fully concurrent every cycle, including to the same address; the result is read-first as defined in Operation.
- There are no stalls or backpressure. Both ports are accepted unconditionally.

## Configuration
- `SPRAM_ASYM_OUTREG_EN` defined:
  - Adds a second output register after the read stage. It is enabled whenever stage 1 holds valid data, i.e. stage-1 valid is the advance condition.
  - Read latency becomes 2; `rq_valid` is delayed to match.
  - `rq` holds when no valid data advances.
  - The output register is mapped onto the BRAM output register.
- `SPRAM_ASYM_OUTREG_EN` undefined: single stage, latency 1, as described above.
- Reset values and read-first semantics are identical in both builds.

## Test plan
- Reset: assert `rst_n=0` mid-run with `rce=1` -> `rq`=0 and `rq_valid`=0 immediately, with no edge needed. After release, with `rce=0`, `rq_valid` stays 0.
- Lane mapping, `RD_WIDTH=8`, `RATIO=4`: write `wa=5`, `wd=32'hDDCCBBAA`, `wbe=4'hF`. Then read `ra`=20, 21, 22, 23 back-to-back -> `rq`=AA, BB, CC, DD on consecutive cycles with `rq_valid=1`.
- Partial write, `RATIO=2`: `wa=3`, `wd=16'h1234`, `wbe=2'b11`; then `wd=16'hFFFF`, `wbe=2'b10`. Reading `ra`=6 and 7 -> 34, FF.
- Collision, `RATIO=2`: address 0 holds 55. Write `wa=0`, `wd=16'h00AA`, `wbe=2'b01` on the same edge as `rce=1`, `ra=0` -> `rq`=55. The next read of `ra=0` -> AA.
- Hold and valid: pulse `rce` for one cycle then idle 3 cycles -> `rq_valid` is high for exactly one cycle and `rq` is stable for all 3 idle cycles.
- Latency: with `SPRAM_ASYM_OUTREG_EN` defined, the same stimulus as the lane-mapping test -> identical data, each arriving one cycle later. Issuing `rce` and asserting reset on the next edge -> no `rq_valid` pulse.
